// File: rtl/riscv_bp_pkg.sv
// rtl/riscv_bp_pkg.sv - shared constants and types for the branch-predictor history front end
package riscv_bp_pkg;

  localparam int BP_IDX_W = 10;
  localparam int BP_DEPTH = 4;
  localparam logic [6:0] BR_OPCODE = 7'b1100011;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - circular FIFO of in-flight predicted branches with flush
module bp_inflight_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // A full FIFO rejects pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/bp_history_unit.sv
// rtl/bp_history_unit.sv - gshare index generation, speculative/architectural GHR and PHT update return
module bp_history_unit
  import riscv_bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int DEPTH = BP_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  output logic [IDX_W-1:0] pht_addr,
  input  logic             pht_predict,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             mispredict
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [IDX_W-1:0] spec_ghr_q, spec_ghr_d, arch_ghr_q, arch_ghr_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             push, pop, flush, full, empty;
  logic [IDX_W:0]   head;
  logic [CW-1:0]    count;
  logic             unused_bits;

  assign pht_addr    = fetch_pc[IDX_W+1:2] ^ spec_ghr_q;
  assign fetch_ready = !full;
  assign push        = fetch_valid && !full;
  assign pop         = resolve_valid && !empty;
  assign flush       = pop && (resolve_taken != head[0]);
  assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0], count};

  bp_inflight_fifo #(
    .DATA_W (IDX_W + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({pht_addr, pht_predict}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    arch_ghr_d   = arch_ghr_q;
    spec_ghr_d   = spec_ghr_q;
    upd_valid_d  = pop;
    mispredict_d = flush;
    upd_idx_d    = upd_idx_q;
    upd_taken_d  = upd_taken_q;
    if (pop) begin
      arch_ghr_d  = {arch_ghr_q[IDX_W-2:0], resolve_taken};
      upd_idx_d   = head[IDX_W:1];
      upd_taken_d = resolve_taken;
    end
    // On mispredict the speculative history is rebuilt from the corrected architectural one.
    if (flush) begin
      spec_ghr_d = arch_ghr_d;
    end else if (push) begin
      spec_ghr_d = {spec_ghr_q[IDX_W-2:0], pht_predict};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      upd_valid_q  <= upd_valid_d;
      upd_idx_q    <= upd_idx_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign upd_valid  = upd_valid_q;
  assign upd_idx    = upd_idx_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispredict_q;

endmodule

// File: tb/tb_bp_history_unit.sv
// tb/tb_bp_history_unit.sv - directed table-driven bench for bp_history_unit
module tb_bp_history_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [9:0]  pht_addr;
  logic        pht_predict;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        upd_valid;
  logic [9:0]  upd_idx;
  logic        upd_taken;
  logic        mispredict;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_history_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_ready   (fetch_ready),
    .pht_addr      (pht_addr),
    .pht_predict   (pht_predict),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .mispredict    (mispredict)
  );

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        pred;
    logic        rv;
    logic        taken;
    logic        e_ready;
    logic [9:0]  e_addr;
    logic        e_uv;
    logic [9:0]  e_uidx;
    logic        e_ut;
    logic        e_mis;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle: check combinational outputs before the edge, registered outputs after it.
  task automatic cycle(input string tag, input vec_t v);
    fetch_valid   = v.fv;
    fetch_pc      = v.pc;
    pht_predict   = v.pred;
    resolve_valid = v.rv;
    resolve_taken = v.taken;
    #1;
    chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(v.e_ready));
    chk({tag, " pht_addr"}, 32'(pht_addr), 32'(v.e_addr));
    @(posedge clk);
    #1;
    chk({tag, " upd_valid"}, 32'(upd_valid), 32'(v.e_uv));
    chk({tag, " upd_idx"}, 32'(upd_idx), 32'(v.e_uidx));
    chk({tag, " upd_taken"}, 32'(upd_taken), 32'(v.e_ut));
    chk({tag, " mispredict"}, 32'(mispredict), 32'(v.e_mis));
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic pred,
                       input logic rv, input logic taken);
    fetch_valid   = fv;
    fetch_pc      = pc;
    pht_predict   = pred;
    resolve_valid = rv;
    resolve_taken = taken;
  endtask

  initial begin
    //            fv  pc     pr rv tk  rdy addr    uv uidx   ut mis
    vecs[0]  = '{1, 32'h10, 1, 0, 0,  1, 10'h004, 0, 10'h000, 0, 0};
    vecs[1]  = '{1, 32'h10, 1, 0, 0,  1, 10'h005, 0, 10'h000, 0, 0};
    vecs[2]  = '{1, 32'h10, 0, 0, 0,  1, 10'h007, 0, 10'h000, 0, 0};
    vecs[3]  = '{1, 32'h10, 1, 0, 0,  1, 10'h002, 0, 10'h000, 0, 0};
    vecs[4]  = '{1, 32'h10, 0, 0, 0,  0, 10'h009, 0, 10'h000, 0, 0};
    vecs[5]  = '{0, 32'h10, 0, 1, 1,  0, 10'h009, 1, 10'h004, 1, 0};
    vecs[6]  = '{1, 32'h10, 0, 1, 1,  1, 10'h009, 1, 10'h005, 1, 0};
    vecs[7]  = '{1, 32'h10, 1, 1, 1,  1, 10'h01E, 1, 10'h007, 1, 1};
    vecs[8]  = '{0, 32'h10, 0, 1, 0,  1, 10'h003, 0, 10'h007, 1, 0};
    vecs[9]  = '{1, 32'h10, 1, 0, 0,  1, 10'h003, 0, 10'h007, 1, 0};
    vecs[10] = '{1, 32'h10, 1, 0, 0,  1, 10'h00B, 0, 10'h007, 1, 0};
    vecs[11] = '{1, 32'h10, 0, 1, 1,  1, 10'h01B, 1, 10'h003, 1, 0};
    vecs[12] = '{0, 32'h10, 0, 1, 0,  1, 10'h03A, 1, 10'h00B, 0, 1};
    vecs[13] = '{0, 32'h10, 0, 0, 0,  1, 10'h01A, 0, 10'h00B, 0, 0};

    rst = 1'b1;
    drive(0, 32'h10, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset upd_valid", 32'(upd_valid), 0);
    chk("reset upd_idx", 32'(upd_idx), 0);
    chk("reset mispredict", 32'(mispredict), 0);
    chk("reset fetch_ready", 32'(fetch_ready), 1);
    chk("reset pht_addr", 32'(pht_addr), 32'h004);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) cycle($sformatf("vec%0d", i), vecs[i]);

    // History wrap: twelve predicted-taken pushes, eleven correct resolves, then a mispredict.
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h0, 1, 1, 1);
      @(posedge clk);
      #1;
    end
    drive(0, 32'h0, 0, 0, 0);
    #1;
    chk("wrap spec_ghr", 32'(pht_addr), 32'h3FF);
    drive(0, 32'h0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("wrap mispredict", 32'(mispredict), 1);
    chk("wrap upd_idx", 32'(upd_idx), 32'h3FF);
    drive(0, 32'h0, 0, 0, 0);
    #1;
    chk("wrap restored ghr", 32'(pht_addr), 32'h3FE);

    // Reset with three branches in flight.
    drive(1, 32'h0, 1, 0, 0); @(posedge clk); #1;
    drive(1, 32'h0, 0, 0, 0); @(posedge clk); #1;
    drive(1, 32'h0, 1, 1, 1); @(posedge clk); #1;
    chk("pre-rst upd_valid", 32'(upd_valid), 1);
    chk("pre-rst upd_idx", 32'(upd_idx), 32'h3FE);
    drive(1, 32'h0, 0, 0, 0); @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 32'h0, 1, 1, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 0);
    #1;
    chk("mid-rst upd_valid", 32'(upd_valid), 0);
    chk("mid-rst upd_idx", 32'(upd_idx), 0);
    chk("mid-rst upd_taken", 32'(upd_taken), 0);
    chk("mid-rst fetch_ready", 32'(fetch_ready), 1);
    chk("mid-rst spec_ghr", 32'(pht_addr), 0);
    drive(0, 32'h0, 0, 1, 1);
    @(posedge clk);
    #1;
    chk("post-rst empty resolve", 32'(upd_valid), 0);
    chk("post-rst no mispredict", 32'(mispredict), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_history_unit.md
# bp_history_unit

Global-history front end for the conditional-branch predictor: builds the gshare index fed to the 2-bit pattern history table (PHT), tracks in-flight predicted branches, and returns each branch's original index and actual outcome to the PHT when it resolves. It keeps a speculative global history register (GHR) updated at fetch and an architectural GHR updated at resolve, and restores the speculative GHR on mispredict. It sits between IF (fetch/decode of branches) and the PHT, with EX resolution feeding back.

## Interface
- IDX_W, 10: PHT index width; also GHR width.
- DEPTH, 4: max in-flight unresolved branches; power of two, ≥2.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_valid  in  1  conditional branch (opcode 1100011) present in IF this cycle
- fetch_pc  in  32  PC of that branch
- fetch_ready  out  1  in-flight FIFO not full; push only when fetch_valid && fetch_ready
- pht_addr  out  IDX_W  PHT lookup index = fetch_pc[IDX_W+1:2] ^ spec_ghr (combinational)
- pht_predict  in  1  PHT prediction for pht_addr, same cycle
- resolve_valid  in  1  oldest in-flight branch resolved in EX
- resolve_taken  in  1  actual outcome of that branch
- upd_valid  out  1  one-cycle pulse: PHT update request
- upd_idx  out  IDX_W  index used when the resolved branch was predicted
- upd_taken  out  1  actual outcome for PHT training
- mispredict  out  1  one-cycle pulse: resolved outcome ≠ stored prediction

## Operation
- State: spec_ghr, arch_ghr (IDX_W each), FIFO of DEPTH entries {idx[IDX_W], pred}, rd/wr pointers, count (0..DEPTH).
- Push (fetch_valid && fetch_ready): write {pht_addr, pht_predict} at wr_ptr; wr_ptr+1 mod DEPTH; spec_ghr <= {spec_ghr[IDX_W-2:0], pht_predict}.
- Pop (resolve_valid && count≠0): read entry at rd_ptr; rd_ptr+1 mod DEPTH; arch_ghr <= {arch_ghr[IDX_W-2:0], resolve_taken}; register upd_valid=1, upd_idx=entry.idx, upd_taken=resolve_taken, mispredict=(resolve_taken≠entry.pred).
- resolve_valid with count=0: ignored, no outputs, no state change.
- Mispredict (pop with mismatch): FIFO flushed (count=0, rd_ptr=wr_ptr=0); spec_ghr <= new arch_ghr value (including the shifted-in outcome); any push in the same cycle is discarded.
- Push and pop same cycle, no mispredict: both take effect; count unchanged; spec_ghr shifts by the push only.
- fetch_ready = (count ≠ DEPTH), from registered count; a full FIFO never accepts a push even if a pop occurs that cycle.
- GHR shifts are pure shifts; oldest bit dropped; no saturation.

## Timing
- Reset values: spec_ghr=0, arch_ghr=0, count=0, pointers=0, upd_valid=0, upd_idx=0, upd_taken=0, mispredict=0; fetch_ready=1 after reset.
- pht_addr: zero-latency combinational from fetch_pc and current spec_ghr.
- upd_*/mispredict: registered, valid the cycle after resolve_valid; held 0 (upd_valid, mispredict) otherwise; upd_idx/upd_taken hold last value.
- spec_ghr update visible to pht_addr the cycle after push; after mispredict, restored value visible the next cycle.
- rst asserted mid-operation: all in-flight entries dropped, outputs cleared at that edge; no update pulse emitted for dropped entries.

## Structure
- Shared package riscv_bp_pkg: IDX_W, DEPTH defaults, branch opcode constant 7'b1100011, in-flight entry struct {idx, pred}.
- Sub-module bp_inflight_fifo: DEPTH-entry circular FIFO with push, pop, flush, count, full/empty; the GHR/index logic stays in bp_history_unit.

## Test plan
- Reset then fetch_pc=0x0000_0010, spec_ghr=0 -> pht_addr=0x004; pht_predict=1 push -> next cycle spec_ghr=0x001, fetch_pc=0x10 gives pht_addr=0x005.
- Push 4 branches (predict 1,1,0,1), no resolves -> fetch_ready=0, spec_ghr=0x00D; fifth fetch_valid not accepted, spec_ghr unchanged.
- Resolve oldest (idx 0x004, pred 1) with taken=1 -> next cycle upd_valid=1, upd_idx=0x004, upd_taken=1, mispredict=0, arch_ghr=0x001, count 3.
- Resolve with taken=0 against pred=1 while fetch_valid=1 -> mispredict=1, count=0, spec_ghr=arch_ghr={old,0}, fetched branch discarded.
- Simultaneous push and correct resolve at count=2 -> count stays 2, single upd_valid pulse, spec_ghr shifted once.
- resolve_valid with empty FIFO -> no upd_valid, no state change; rst with 3 entries in flight -> count=0, GHRs=0, no upd pulse.
